// File: rtl/rs_station_param.sv
`default_nettype none
// ============================================================================
// Module   : rs_station_param
// Purpose  : Parametrised reservation station. Holds up to DEPTH waiting
//            instructions, wakes operands from CDB_N broadcast channels and
//            issues the oldest ready entry through a valid/ready register.
// Option   : RS_BYPASS_EN - when defined, a ready dispatch with no ready
//            entry waiting goes straight into the issue register.
// Revision : 1.0  initial release
// ============================================================================
module rs_station_param #(
  parameter int DEPTH = 16,
  parameter int TAG_W = 4,
  parameter int OP_W  = 6,
  parameter int XLEN  = 32,
  parameter int CDB_N = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rdy,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [OP_W-1:0]          in_op,
  input  logic                     in_rs1_rdy,
  input  logic                     in_rs2_rdy,
  input  logic [XLEN-1:0]          in_rs1,
  input  logic [XLEN-1:0]          in_rs2,
  input  logic                     in_use_imm,
  input  logic [XLEN-1:0]          in_imm,
  input  logic [TAG_W-1:0]         in_rob,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  input  logic [CDB_N-1:0]         cdb_valid,
  input  logic [CDB_N*TAG_W-1:0]   cdb_tag,
  input  logic [CDB_N*XLEN-1:0]    cdb_val,
  output logic                     ex_valid,
  input  logic                     ex_ready,
  output logic [OP_W-1:0]          ex_op,
  output logic [XLEN-1:0]          ex_vj,
  output logic [XLEN-1:0]          ex_vk,
  output logic [XLEN-1:0]          ex_imm,
  output logic [TAG_W-1:0]         ex_rob
);

  localparam int IW = $clog2(DEPTH);

  // Entry storage; an operand not yet ready keeps its ROB tag in the low bits
  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] r_qj_rdy;
  logic [DEPTH-1:0] r_qk_rdy;
  logic [OP_W-1:0]  r_op  [DEPTH];
  logic [XLEN-1:0]  r_vj  [DEPTH];
  logic [XLEN-1:0]  r_vk  [DEPTH];
  logic [XLEN-1:0]  r_imm [DEPTH];
  logic [TAG_W-1:0] r_rob [DEPTH];
  // r_older[i][j] set means entry i was dispatched before entry j
  logic [DEPTH-1:0] r_older [DEPTH];
  logic [IW:0]      r_count;

  logic             r_ex_valid;
  logic [OP_W-1:0]  r_ex_op;
  logic [XLEN-1:0]  r_ex_vj;
  logic [XLEN-1:0]  r_ex_vk;
  logic [XLEN-1:0]  r_ex_imm;
  logic [TAG_W-1:0] r_ex_rob;

  // Lowest-index CDB channel carrying the tag wins; result is {hit, value}
  function automatic logic [XLEN:0] cdb_lookup(input logic [TAG_W-1:0] tag);
    logic [XLEN:0] res;
    res = '0;
    for (int k = CDB_N - 1; k >= 0; k--) begin
      if (cdb_valid[k] && (cdb_tag[k*TAG_W +: TAG_W] == tag))
        res = {1'b1, cdb_val[k*XLEN +: XLEN]};
    end
    return res;
  endfunction

  logic [XLEN:0]    w_in_j;
  logic [XLEN:0]    w_in_k;
  logic             w_in_j_rdy;
  logic             w_in_k_rdy;
  logic [XLEN-1:0]  w_in_vj;
  logic [XLEN-1:0]  w_in_vk;

  // Dispatch-time operand capture, including same-cycle CDB wakeup
  always_comb begin
    w_in_j     = cdb_lookup(in_rs1[TAG_W-1:0]);
    w_in_k     = cdb_lookup(in_rs2[TAG_W-1:0]);
    w_in_j_rdy = in_rs1_rdy | w_in_j[XLEN];
    w_in_vj    = in_rs1_rdy ? in_rs1 : (w_in_j[XLEN] ? w_in_j[XLEN-1:0] : in_rs1);
    w_in_k_rdy = in_use_imm | in_rs2_rdy | w_in_k[XLEN];
    if (in_use_imm)
      w_in_vk = in_imm;
    else if (in_rs2_rdy)
      w_in_vk = in_rs2;
    else
      w_in_vk = w_in_k[XLEN] ? w_in_k[XLEN-1:0] : in_rs2;
  end

  logic [XLEN:0]    w_wake_j [DEPTH];
  logic [XLEN:0]    w_wake_k [DEPTH];

  // CDB tag compare for every stored operand
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_wake_j[i] = cdb_lookup(r_vj[i][TAG_W-1:0]);
      w_wake_k[i] = cdb_lookup(r_vk[i][TAG_W-1:0]);
    end
  end

  logic [DEPTH-1:0] w_ready;
  logic [DEPTH-1:0] w_is_oldest;
  logic             w_any_ready;
  logic [IW-1:0]    w_sel_idx;
  logic [IW-1:0]    w_free_idx;

  // Oldest-ready select through the age matrix, plus lowest free slot
  always_comb begin
    w_ready     = r_busy & r_qj_rdy & r_qk_rdy;
    w_any_ready = |w_ready;
    w_sel_idx   = '0;
    w_free_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_is_oldest[i] = w_ready[i];
      for (int j = 0; j < DEPTH; j++) begin
        if ((j != i) && w_ready[j] && !r_older[i][j])
          w_is_oldest[i] = 1'b0;
      end
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w_is_oldest[i]) w_sel_idx = IW'(i);
      if (!r_busy[i])     w_free_idx = IW'(i);
    end
  end

  logic w_adv;
  logic w_issue;
  logic w_disp;
  logic w_bypass;
  logic w_alloc;

  assign w_adv   = !r_ex_valid || ex_ready;
  assign w_issue = w_adv && w_any_ready;
  assign w_disp  = in_valid && !full;
`ifdef RS_BYPASS_EN
  assign w_bypass = w_disp && w_in_j_rdy && w_in_k_rdy && !w_any_ready && w_adv;
`else
  assign w_bypass = 1'b0;
`endif
  assign w_alloc = w_disp && !w_bypass;

  // Station state: reset > hold when !rdy > flush > wakeup/issue/dispatch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy     <= '0;
      r_qj_rdy   <= '0;
      r_qk_rdy   <= '0;
      r_count    <= '0;
      r_ex_valid <= 1'b0;
      r_ex_op    <= '0;
      r_ex_vj    <= '0;
      r_ex_vk    <= '0;
      r_ex_imm   <= '0;
      r_ex_rob   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_op[i]    <= '0;
        r_vj[i]    <= '0;
        r_vk[i]    <= '0;
        r_imm[i]   <= '0;
        r_rob[i]   <= '0;
        r_older[i] <= '0;
      end
    end else if (rdy) begin
      if (flush) begin
        r_busy     <= '0;
        r_count    <= '0;
        r_ex_valid <= 1'b0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (r_busy[i] && !r_qj_rdy[i] && w_wake_j[i][XLEN]) begin
            r_vj[i]     <= w_wake_j[i][XLEN-1:0];
            r_qj_rdy[i] <= 1'b1;
          end
          if (r_busy[i] && !r_qk_rdy[i] && w_wake_k[i][XLEN]) begin
            r_vk[i]     <= w_wake_k[i][XLEN-1:0];
            r_qk_rdy[i] <= 1'b1;
          end
        end
        if (w_issue)
          r_busy[w_sel_idx] <= 1'b0;
        if (w_alloc) begin
          r_busy[w_free_idx]   <= 1'b1;
          r_op[w_free_idx]     <= in_op;
          r_vj[w_free_idx]     <= w_in_vj;
          r_qj_rdy[w_free_idx] <= w_in_j_rdy;
          r_vk[w_free_idx]     <= w_in_vk;
          r_qk_rdy[w_free_idx] <= w_in_k_rdy;
          r_imm[w_free_idx]    <= in_imm;
          r_rob[w_free_idx]    <= in_rob;
          r_older[w_free_idx]  <= '0;
          for (int j = 0; j < DEPTH; j++)
            r_older[j][w_free_idx] <= r_busy[j];
        end
        r_count <= r_count + (IW+1)'(w_alloc) - (IW+1)'(w_issue);
        if (w_issue) begin
          r_ex_valid <= 1'b1;
          r_ex_op    <= r_op[w_sel_idx];
          r_ex_vj    <= r_vj[w_sel_idx];
          r_ex_vk    <= r_vk[w_sel_idx];
          r_ex_imm   <= r_imm[w_sel_idx];
          r_ex_rob   <= r_rob[w_sel_idx];
        end else if (w_bypass) begin
          r_ex_valid <= 1'b1;
          r_ex_op    <= in_op;
          r_ex_vj    <= w_in_vj;
          r_ex_vk    <= w_in_vk;
          r_ex_imm   <= in_imm;
          r_ex_rob   <= in_rob;
        end else if (w_adv) begin
          r_ex_valid <= 1'b0;
        end
      end
    end
  end

  assign full     = (r_count == (IW+1)'(DEPTH));
  assign count    = r_count;
  assign ex_valid = r_ex_valid;
  assign ex_op    = r_ex_op;
  assign ex_vj    = r_ex_vj;
  assign ex_vk    = r_ex_vk;
  assign ex_imm   = r_ex_imm;
  assign ex_rob   = r_ex_rob;

endmodule
`default_nettype wire

// File: tb/tb_rs_station_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_rs_station_param
// Purpose  : Directed self-checking bench for rs_station_param (default
//            build, bypass disabled).
// Revision : 1.0  initial release
// ============================================================================
module tb_rs_station_param;

  localparam int DEPTH = 16;
  localparam int TAG_W = 4;
  localparam int OP_W  = 6;
  localparam int XLEN  = 32;
  localparam int CDB_N = 2;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   rdy;
  logic                   flush;
  logic                   in_valid;
  logic [OP_W-1:0]        in_op;
  logic                   in_rs1_rdy;
  logic                   in_rs2_rdy;
  logic [XLEN-1:0]        in_rs1;
  logic [XLEN-1:0]        in_rs2;
  logic                   in_use_imm;
  logic [XLEN-1:0]        in_imm;
  logic [TAG_W-1:0]       in_rob;
  logic                   full;
  logic [4:0]             count;
  logic [CDB_N-1:0]       cdb_valid;
  logic [CDB_N*TAG_W-1:0] cdb_tag;
  logic [CDB_N*XLEN-1:0]  cdb_val;
  logic                   ex_valid;
  logic                   ex_ready;
  logic [OP_W-1:0]        ex_op;
  logic [XLEN-1:0]        ex_vj;
  logic [XLEN-1:0]        ex_vk;
  logic [XLEN-1:0]        ex_imm;
  logic [TAG_W-1:0]       ex_rob;

  int n_checks = 0;
  int n_errors = 0;

  rs_station_param #(
    .DEPTH(DEPTH), .TAG_W(TAG_W), .OP_W(OP_W), .XLEN(XLEN), .CDB_N(CDB_N)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
    .in_valid(in_valid), .in_op(in_op),
    .in_rs1_rdy(in_rs1_rdy), .in_rs2_rdy(in_rs2_rdy),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_use_imm(in_use_imm), .in_imm(in_imm), .in_rob(in_rob),
    .full(full), .count(count),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_op(ex_op), .ex_vj(ex_vj), .ex_vk(ex_vk), .ex_imm(ex_imm), .ex_rob(ex_rob)
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs are examined 1 time unit after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; in_op = '0; in_rs1_rdy = 0; in_rs2_rdy = 0;
    in_rs1 = '0; in_rs2 = '0; in_use_imm = 0; in_imm = '0; in_rob = '0;
    cdb_valid = '0; cdb_tag = '0; cdb_val = '0; flush = 0;
  endtask

  task automatic disp(input logic r1, input logic [31:0] v1,
                      input logic r2, input logic [31:0] v2,
                      input logic [3:0] rob);
    in_valid = 1; in_op = 6'd1; in_rs1_rdy = r1; in_rs1 = v1;
    in_rs2_rdy = r2; in_rs2 = v2; in_use_imm = 0; in_imm = 32'h33; in_rob = rob;
  endtask

  task automatic bcast(input int ch, input logic [3:0] tag, input logic [31:0] val);
    cdb_valid[ch] = 1'b1;
    cdb_tag[ch*TAG_W +: TAG_W] = tag;
    cdb_val[ch*XLEN +: XLEN] = val;
  endtask

  task automatic test_reset();
    idle(); rdy = 1; ex_ready = 1; rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (ex_valid !== 1'b0) begin n_errors++; $display("FAIL reset_ex_valid: got %0b want 0", ex_valid); end
    n_checks++; if (count !== 5'd0) begin n_errors++; $display("FAIL reset_count: got %0d want 0", count); end
    n_checks++; if (full !== 1'b0) begin n_errors++; $display("FAIL reset_full: got %0b want 0", full); end
    n_checks++; if (ex_rob !== 4'd0 || ex_vj !== 32'd0) begin n_errors++; $display("FAIL reset_fields: got rob=%0d vj=%0h want 0", ex_rob, ex_vj); end
    rst_n = 1;
    step();
  endtask

  task automatic test_basic();
    idle(); ex_ready = 1;
    disp(1, 32'd5, 1, 32'd7, 4'd3);
    step();
    idle();
    n_checks++; if (ex_valid !== 1'b0 || count !== 5'd1) begin n_errors++; $display("FAIL basic_e0: got valid=%0b count=%0d want valid=0 count=1", ex_valid, count); end
    step();
    n_checks++; if (ex_valid !== 1'b1) begin n_errors++; $display("FAIL basic_valid: got %0b want 1", ex_valid); end
    n_checks++; if (ex_vj !== 32'd5 || ex_vk !== 32'd7) begin n_errors++; $display("FAIL basic_ops: got vj=%0d vk=%0d want 5 7", ex_vj, ex_vk); end
    n_checks++; if (ex_rob !== 4'd3 || ex_op !== 6'd1 || ex_imm !== 32'h33) begin n_errors++; $display("FAIL basic_fields: got rob=%0d op=%0d imm=%0h want 3 1 33", ex_rob, ex_op, ex_imm); end
    n_checks++; if (count !== 5'd0) begin n_errors++; $display("FAIL basic_count: got %0d want 0", count); end
    step();
    n_checks++; if (ex_valid !== 1'b0) begin n_errors++; $display("FAIL basic_drain: got %0b want 0", ex_valid); end
  endtask

  task automatic test_wakeup();
    idle(); ex_ready = 1;
    disp(0, 32'd2, 1, 32'd1, 4'd4);          // A waits on tag 2
    step();
    disp(1, 32'h20, 1, 32'h21, 4'd5);        // B ready
    step();
    idle(); bcast(1, 4'd2, 32'h10);
    step();
    idle();
    n_checks++; if (ex_valid !== 1'b1 || ex_rob !== 4'd5) begin n_errors++; $display("FAIL wake_b_first: got valid=%0b rob=%0d want 1 5", ex_valid, ex_rob); end
    step();
    n_checks++; if (ex_valid !== 1'b1 || ex_rob !== 4'd4) begin n_errors++; $display("FAIL wake_a_issue: got valid=%0b rob=%0d want 1 4", ex_valid, ex_rob); end
    n_checks++; if (ex_vj !== 32'h10 || ex_vk !== 32'd1) begin n_errors++; $display("FAIL wake_a_ops: got vj=%0h vk=%0h want 10 1", ex_vj, ex_vk); end
    step();
    n_checks++; if (ex_valid !== 1'b0 || count !== 5'd0) begin n_errors++; $display("FAIL wake_drain: got valid=%0b count=%0d want 0 0", ex_valid, count); end
  endtask

  task automatic test_cdb_priority();
    idle(); ex_ready = 1;
    disp(1, 32'd3, 0, 32'd6, 4'd7);          // waits on tag 6 in rs2
    step();
    idle(); bcast(0, 4'd6, 32'hAA); bcast(1, 4'd6, 32'hBB);
    step();
    idle();
    step();
    n_checks++; if (ex_valid !== 1'b1 || ex_vk !== 32'hAA) begin n_errors++; $display("FAIL cdb_low_channel: got valid=%0b vk=%0h want 1 aa", ex_valid, ex_vk); end
    // operand captured from the CDB in the dispatch cycle itself
    disp(0, 32'd8, 1, 32'd9, 4'd8); bcast(1, 4'd8, 32'h55);
    step();
    idle();
    step();
    n_checks++; if (ex_valid !== 1'b1 || ex_rob !== 4'd8 || ex_vj !== 32'h55) begin n_errors++; $display("FAIL cdb_dispatch_wake: got valid=%0b rob=%0d vj=%0h want 1 8 55", ex_valid, ex_rob, ex_vj); end
    step();
  endtask

  task automatic test_age_order();
    idle(); ex_ready = 1;
    disp(0, 32'd3, 1, 32'd0, 4'd1);          // P -> slot 0, tag 3
    step();
    disp(0, 32'd4, 1, 32'd0, 4'd2);          // Q -> slot 1, tag 4
    step();
    idle(); bcast(0, 4'd3, 32'h1);
    step();
    idle();
    step();                                  // P issues, slot 0 freed
    n_checks++; if (ex_valid !== 1'b1 || ex_rob !== 4'd1) begin n_errors++; $display("FAIL age_p: got valid=%0b rob=%0d want 1 1", ex_valid, ex_rob); end
    disp(0, 32'd4, 1, 32'd0, 4'd3);          // R -> slot 0, younger than Q
    step();
    idle(); bcast(1, 4'd4, 32'h2);
    step();
    idle();
    step();
    n_checks++; if (ex_valid !== 1'b1 || ex_rob !== 4'd2) begin n_errors++; $display("FAIL age_q_first: got valid=%0b rob=%0d want 1 2", ex_valid, ex_rob); end
    step();
    n_checks++; if (ex_valid !== 1'b1 || ex_rob !== 4'd3) begin n_errors++; $display("FAIL age_r_second: got valid=%0b rob=%0d want 1 3", ex_valid, ex_rob); end
    step();
  endtask

  task automatic test_full();
    idle(); ex_ready = 1;
    for (int i = 0; i < DEPTH; i++) begin
      disp(0, 32'd9, 1, 32'(i), 4'(i));
      step();
    end
    disp(1, 32'd1, 1, 32'd1, 4'd14);         // must be ignored
    n_checks++; if (full !== 1'b1 || count !== 5'd16) begin n_errors++; $display("FAIL full_set: got full=%0b count=%0d want 1 16", full, count); end
    step();
    idle();
    n_checks++; if (count !== 5'd16 || ex_valid !== 1'b0) begin n_errors++; $display("FAIL full_ignore: got count=%0d valid=%0b want 16 0", count, ex_valid); end
    bcast(0, 4'd9, 32'h99);
    step();
    idle();
    n_checks++; if (full !== 1'b1 || ex_valid !== 1'b0) begin n_errors++; $display("FAIL full_wake: got full=%0b valid=%0b want 1 0", full, ex_valid); end
    step();
    n_checks++; if (ex_valid !== 1'b1 || ex_rob !== 4'd0 || full !== 1'b0 || count !== 5'd15) begin n_errors++; $display("FAIL full_first_issue: got valid=%0b rob=%0d full=%0b count=%0d want 1 0 0 15", ex_valid, ex_rob, full, count); end
    for (int i = 1; i < DEPTH; i++) begin
      step();
      n_checks++; if (ex_valid !== 1'b1 || ex_rob !== 4'(i) || ex_vk !== 32'(i) || ex_vj !== 32'h99) begin n_errors++; $display("FAIL full_order_%0d: got valid=%0b rob=%0d vk=%0d vj=%0h want 1 %0d %0d 99", i, ex_valid, ex_rob, ex_vk, ex_vj, i, i); end
    end
    step();
    n_checks++; if (ex_valid !== 1'b0 || count !== 5'd0) begin n_errors++; $display("FAIL full_drain: got valid=%0b count=%0d want 0 0", ex_valid, count); end
  endtask

  task automatic test_back_pressure();
    idle(); ex_ready = 0;
    disp(1, 32'hA1, 1, 32'hA2, 4'd10);
    step();
    disp(1, 32'hB1, 1, 32'hB2, 4'd11);
    step();
    idle();
    for (int c = 0; c < 5; c++) begin
      n_checks++; if (ex_valid !== 1'b1 || ex_rob !== 4'd10 || ex_vj !== 32'hA1 || ex_vk !== 32'hA2 || count !== 5'd1) begin n_errors++; $display("FAIL stall_hold_%0d: got valid=%0b rob=%0d vj=%0h vk=%0h count=%0d want 1 10 a1 a2 1", c, ex_valid, ex_rob, ex_vj, ex_vk, count); end
      step();
    end
    ex_ready = 1;
    n_checks++; if (ex_rob !== 4'd10) begin n_errors++; $display("FAIL stall_last: got rob=%0d want 10", ex_rob); end
    step();
    n_checks++; if (ex_valid !== 1'b1 || ex_rob !== 4'd11 || ex_vj !== 32'hB1 || count !== 5'd0) begin n_errors++; $display("FAIL stall_next: got valid=%0b rob=%0d vj=%0h count=%0d want 1 11 b1 0", ex_valid, ex_rob, ex_vj, count); end
    step();
    n_checks++; if (ex_valid !== 1'b0) begin n_errors++; $display("FAIL stall_drain: got %0b want 0", ex_valid); end
  endtask

  task automatic test_flush();
    idle(); ex_ready = 0;
    disp(1, 32'd1, 1, 32'd2, 4'd1);          // parks in issue register
    step();
    for (int i = 0; i < 4; i++) begin
      disp(0, 32'd12, 1, 32'd0, 4'(2 + i));
      step();
    end
    n_checks++; if (count !== 5'd4 || ex_valid !== 1'b1) begin n_errors++; $display("FAIL flush_pre: got count=%0d valid=%0b want 4 1", count, ex_valid); end
    disp(1, 32'd7, 1, 32'd7, 4'd9); flush = 1;
    step();
    idle(); ex_ready = 1;
    n_checks++; if (count !== 5'd0 || ex_valid !== 1'b0) begin n_errors++; $display("FAIL flush_clear: got count=%0d valid=%0b want 0 0", count, ex_valid); end
    step();
    n_checks++; if (count !== 5'd0 || ex_valid !== 1'b0) begin n_errors++; $display("FAIL flush_no_write: got count=%0d valid=%0b want 0 0", count, ex_valid); end
    bcast(0, 4'd12, 32'h5);
    step();
    idle();
    step();
    n_checks++; if (ex_valid !== 1'b0) begin n_errors++; $display("FAIL flush_gone: got %0b want 0", ex_valid); end
  endtask

  task automatic test_hold();
    idle(); ex_ready = 1;
    disp(0, 32'd5, 1, 32'h77, 4'd6);
    step();
    idle();
    n_checks++; if (count !== 5'd1) begin n_errors++; $display("FAIL hold_pre: got count=%0d want 1", count); end
    rdy = 0;
    disp(1, 32'd1, 1, 32'd1, 4'd12); bcast(0, 4'd5, 32'hEE);
    step();
    n_checks++; if (count !== 5'd1 || ex_valid !== 1'b0) begin n_errors++; $display("FAIL hold_frozen: got count=%0d valid=%0b want 1 0", count, ex_valid); end
    rdy = 1; idle();
    step();
    n_checks++; if (count !== 5'd1 || ex_valid !== 1'b0) begin n_errors++; $display("FAIL hold_no_wake: got count=%0d valid=%0b want 1 0", count, ex_valid); end
    bcast(1, 4'd5, 32'h3C);
    step();
    idle();
    step();
    n_checks++; if (ex_valid !== 1'b1 || ex_rob !== 4'd6 || ex_vj !== 32'h3C || count !== 5'd0) begin n_errors++; $display("FAIL hold_resume: got valid=%0b rob=%0d vj=%0h count=%0d want 1 6 3c 0", ex_valid, ex_rob, ex_vj, count); end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wakeup();
    test_cdb_priority();
    test_age_order();
    test_full();
    test_back_pressure();
    test_flush();
    test_hold();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rs_station_param.md
# rs_station_param

Parametrised reservation station for the out-of-order core. It sits between the decoder/ROB dispatch stage and one execution unit.
- Holds up to DEPTH waiting instructions.
- Wakes operands from CDB_N common-data-bus channels.
- Issues the oldest ready instruction to the unit through a valid/ready handshake.
- Generalises the single-CDB, fixed-32-entry station to configurable depth, tag width, operand width and broadcast channel count, and adds age-ordered select, flush and back-pressure.

## Interface
Parameters:
- DEPTH, 16, number of entries (power of two, 2..32)
- TAG_W, 4, ROB tag width
- OP_W, 6, opcode id width
- XLEN, 32, operand width
- CDB_N, 2, number of broadcast channels

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- rdy  in  1  global enable; low freezes all state
- flush  in  1  mispredict flush, synchronous
- in_valid  in  1  dispatch request
- in_op  in  OP_W  opcode id
- in_rs1_rdy, in_rs2_rdy  in  1 each  operand already holds a value
- in_rs1, in_rs2  in  XLEN each  operand value when ready; otherwise ROB tag in bits [TAG_W-1:0]
- in_use_imm  in  1  second operand is the immediate; rs2 is treated as ready
- in_imm  in  XLEN  immediate
- in_rob  in  TAG_W  destination ROB tag
- full  out  1  no free entry
- count  out  clog2(DEPTH)+1  occupied entries
- cdb_valid  in  CDB_N  broadcast valid per channel
- cdb_tag  in  CDB_N*TAG_W  packed tags; channel k at [k*TAG_W +: TAG_W]
- cdb_val  in  CDB_N*XLEN  packed values
- ex_valid  out  1  issue register holds an instruction
- ex_ready  in  1  execution unit accepts
- ex_op, ex_vj, ex_vk, ex_imm, ex_rob  out  —  issued fields

## Operation
- Entry state per slot: busy, op, vj/qj_rdy, vk/qk_rdy, imm, rob.
- Age matrix (DEPTH×DEPTH bits) records the dispatch order of entries.
- Dispatch: when in_valid && !full, write into the lowest-index free slot. That slot becomes younger than every busy slot.
- Dispatch with full=1: the request is ignored and state is unchanged. The decoder must not do this.
- Dispatch-time wakeup: a not-ready in_rs tag that matches a valid CDB channel in the same cycle is captured as a value.
- Wakeup: for each busy entry with a not-ready operand, compare its tag against all CDB channels. On a match, latch the value and set the ready bit.
  - Several channels with the same tag: the lowest channel index wins.
- Select: among entries that are busy with both operands ready, pick the oldest by age matrix.
  - The select result loads the issue register when !ex_valid || ex_ready.
  - The selected entry is freed on that same edge.
- Issue register: holds its fields stable while ex_valid && !ex_ready.
- full = (count == DEPTH), from registered state only. A slot freed this cycle is reusable from the next cycle.
- Precedence at each edge: reset > !rdy (hold everything, including ignoring CDB) > flush > normal.
- Flush: clears all busy bits and ex_valid. A dispatch in the same cycle is dropped.
- Reset values: every busy bit 0, age matrix 0, ex_valid 0, ex_* fields 0, count 0, full 0.
- Reset mid-operation discards all entries immediately, asynchronously.

## Timing
- Dispatch with both operands ready, accepted at edge E0:
  - selectable in the cycle after E0;
  - ex_valid high after E1 at the earliest (1-cycle dispatch-to-issue).
- CDB wakeup at edge E: the entry is selectable after E, so ex_valid rises after E+1.
- One issue per cycle, one dispatch per cycle; both may happen on the same edge.
- With ex_ready held high, the issue rate is 1/cycle.
- count updates on the edge: +1 on dispatch, −1 on free, net 0 when both happen.

## Configuration
- RS_BYPASS_EN defined: bypass path is enabled.
  - Condition: a dispatched instruction is ready after dispatch-time wakeup, no busy entry is ready, and the issue register is free or being consumed.
  - Effect: the instruction loads the issue register directly at E0 without occupying a slot, so ex_valid is high after E0.
  - count and the age matrix are unchanged for that instruction.
- RS_BYPASS_EN undefined: every instruction passes through an entry, so minimum latency is 1 cycle.

## Test plan
- Reset, then dispatch op=ADD, rs1=5, rs2=7 (both ready), rob=3, ex_ready=1:
  - ex_valid high one cycle later (same edge with bypass) with ex_vj=5, ex_vk=7, ex_rob=3.
  - count returns to 0.
- Dispatch A waiting on tag 2, then B ready; then cdb channel 1 tag=2 val=0x10:
  - B issues first.
  - A issues two cycles after the broadcast with vj=0x10.
- Fill DEPTH entries, all waiting on tag 9:
  - full=1, count=DEPTH, and a further in_valid is ignored.
  - Broadcast tag 9: entries issue oldest-first, one per cycle.
  - full drops the cycle after the first issue.
- Hold ex_ready=0 with ex_valid=1 for 5 cycles: ex_* fields remain stable and the entry is not lost.
- Dispatch 4 entries, then assert flush together with in_valid: next cycle count=0, ex_valid=0, and no entry was written.
- Dispatch while rdy=0 with a CDB broadcast on the same cycle: no state changes; count and entries are identical to the previous cycle.
